// File: rtl/dmem_arbiter.sv
// Per-cycle arbiter sharing the single-port data memory between the CPU (port C) and an aux master (port A).
// The CPU has priority; a saturating wait counter forces an aux grant after MAX_WAIT consecutive denials.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [DATA_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_stall,
  output logic                  c_rvalid,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [DATA_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_w_en,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  input  logic [DATA_WIDTH-1:0] mem_r_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_C = 2'd1,
    RD_A = 2'd2
  } state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    // NOTE: every output and next-state value is defaulted first so no path leaves a latch.
    c_gnt      = 1'b0;
    a_gnt      = 1'b0;
    mem_w_en   = 1'b0;
    mem_addr   = '0;
    mem_w_data = '0;
    state_d    = IDLE;
    wait_cnt_d = '0;

    // Grants are forced low while reset is held so no write can slip out.
    a_gnt = reset && a_req && (!c_req || wait_cnt_q == MAX_WAIT_C);
    c_gnt = reset && c_req && !a_gnt;

    if (reset) begin
      if (a_gnt) begin
        mem_addr   = a_addr;
        mem_w_data = a_wdata;
        mem_w_en   = a_we;
      end else begin
        mem_addr   = c_addr;
        mem_w_data = c_wdata;
        mem_w_en   = c_gnt && c_we;
      end
    end

    if (c_gnt && !c_we) begin
      state_d = RD_C;
    end else if (a_gnt && !a_we) begin
      state_d = RD_A;
    end

    if (a_req && !a_gnt) begin
      wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign c_stall  = c_req && !c_gnt;
  assign c_rvalid = (state_q == RD_C);
  assign a_rvalid = (state_q == RD_A);
  assign rdata    = mem_r_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-cycle behaviour, hand sequences for
// starvation, reset and memory-ordering corners. Includes a small synchronous-read memory model.
module tb_dmem_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, a_req, a_we;
  logic [DW-1:0] c_addr, c_wdata, a_addr, a_wdata;
  logic          c_gnt, c_stall, c_rvalid, a_gnt, a_rvalid, mem_w_en;
  logic [DW-1:0] rdata, mem_addr, mem_w_data, mem_r_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem [0:63];

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .c_req      (c_req),
    .c_we       (c_we),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .c_gnt      (c_gnt),
    .c_stall    (c_stall),
    .c_rvalid   (c_rvalid),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_gnt      (a_gnt),
    .a_rvalid   (a_rvalid),
    .rdata      (rdata),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data)
  );

  // Single-port memory: write on edge, read data registered one cycle after address.
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr[7:2]] <= mem_w_data;
    mem_r_data <= mem[mem_addr[7:2]];
  end

  typedef struct {
    logic          c_req, c_we;
    logic [DW-1:0] c_addr, c_wdata;
    logic          a_req, a_we;
    logic [DW-1:0] a_addr, a_wdata;
    logic          e_cg, e_ag, e_cs, e_cr, e_ar, e_we;
    logic [DW-1:0] e_addr, e_wd;
    logic          chk_rd;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [DW-1:0] ca, input logic [DW-1:0] cd,
                       input logic ar, input logic aw, input logic [DW-1:0] aa, input logic [DW-1:0] ad);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
  endtask

  initial begin
    //            c_req c_we c_addr  c_wdata       a_req a_we a_addr  a_wdata       cg ag cs cr ar we e_addr  e_wd          chk e_rd
    vecs[0]  = '{1'b0,1'b0,32'h00,32'h0,         1'b0,1'b0,32'h00,32'h0,         0,0,0,0,0,0,32'h00,32'h0,         0,32'h0};
    vecs[1]  = '{1'b0,1'b0,32'h00,32'h0,         1'b1,1'b1,32'h20,32'h12345678,  0,1,0,0,0,1,32'h20,32'h12345678,  0,32'h0};
    vecs[2]  = '{1'b1,1'b1,32'h10,32'hDEADBEEF,  1'b0,1'b0,32'h00,32'h0,         1,0,0,0,0,1,32'h10,32'hDEADBEEF,  0,32'h0};
    vecs[3]  = '{1'b1,1'b0,32'h10,32'h0,         1'b0,1'b0,32'h00,32'h0,         1,0,0,0,0,0,32'h10,32'h0,         0,32'h0};
    vecs[4]  = '{1'b0,1'b0,32'h00,32'h0,         1'b0,1'b0,32'h00,32'h0,         0,0,0,1,0,0,32'h00,32'h0,         1,32'hDEADBEEF};
    vecs[5]  = '{1'b0,1'b0,32'h00,32'h0,         1'b1,1'b0,32'h20,32'h0,         0,1,0,0,0,0,32'h20,32'h0,         0,32'h0};
    vecs[6]  = '{1'b0,1'b0,32'h00,32'h0,         1'b0,1'b0,32'h00,32'h0,         0,0,0,0,1,0,32'h00,32'h0,         1,32'h12345678};
    vecs[7]  = '{1'b1,1'b1,32'h30,32'hA5A5A5A5,  1'b1,1'b0,32'h30,32'h0,         1,0,0,0,0,1,32'h30,32'hA5A5A5A5,  0,32'h0};
    vecs[8]  = '{1'b0,1'b0,32'h00,32'h0,         1'b1,1'b0,32'h30,32'h0,         0,1,0,0,0,0,32'h30,32'h0,         0,32'h0};
    vecs[9]  = '{1'b0,1'b0,32'h00,32'h0,         1'b0,1'b0,32'h00,32'h0,         0,0,0,0,1,0,32'h00,32'h0,         1,32'hA5A5A5A5};
    vecs[10] = '{1'b1,1'b0,32'h10,32'h0,         1'b0,1'b0,32'h00,32'h0,         1,0,0,0,0,0,32'h10,32'h0,         0,32'h0};
    vecs[11] = '{1'b0,1'b0,32'h00,32'h0,         1'b1,1'b0,32'h20,32'h0,         0,1,0,1,0,0,32'h20,32'h0,         1,32'hDEADBEEF};
    vecs[12] = '{1'b1,1'b0,32'h30,32'h0,         1'b0,1'b0,32'h00,32'h0,         1,0,0,0,1,0,32'h30,32'h0,         1,32'h12345678};
    vecs[13] = '{1'b0,1'b0,32'h00,32'h0,         1'b0,1'b0,32'h00,32'h0,         0,0,0,1,0,0,32'h00,32'h0,         1,32'hA5A5A5A5};
    vecs[14] = '{1'b0,1'b0,32'h00,32'h0,         1'b1,1'b1,32'h24,32'h00000055,  0,1,0,0,0,1,32'h24,32'h00000055,  0,32'h0};
    vecs[15] = '{1'b0,1'b0,32'h00,32'h0,         1'b0,1'b0,32'h00,32'h0,         0,0,0,0,0,0,32'h00,32'h0,         0,32'h0};

    // Reset held with both ports requesting writes: nothing may be granted or written.
    reset = 1'b0;
    drive(1'b1, 1'b1, 32'h3C, 32'h11111111, 1'b1, 1'b1, 32'h38, 32'h22222222);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_c_gnt", 32'(c_gnt), 32'h0);
    check("rst_a_gnt", 32'(a_gnt), 32'h0);
    check("rst_w_en", 32'(mem_w_en), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_w_data, 32'h0);
    check("rst_rvalid", {30'h0, c_rvalid, a_rvalid}, 32'h0);
    reset = 1'b1;
    #1;
    check("rel_c_gnt", 32'(c_gnt), 32'h1);
    check("rel_a_gnt", 32'(a_gnt), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata,
            vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata);
      @(negedge clk);
      check($sformatf("v%0d_c_gnt", i),    32'(c_gnt),    32'(vecs[i].e_cg));
      check($sformatf("v%0d_a_gnt", i),    32'(a_gnt),    32'(vecs[i].e_ag));
      check($sformatf("v%0d_c_stall", i),  32'(c_stall),  32'(vecs[i].e_cs));
      check($sformatf("v%0d_c_rvalid", i), 32'(c_rvalid), 32'(vecs[i].e_cr));
      check($sformatf("v%0d_a_rvalid", i), 32'(a_rvalid), 32'(vecs[i].e_ar));
      check($sformatf("v%0d_w_en", i),     32'(mem_w_en), 32'(vecs[i].e_we));
      check($sformatf("v%0d_addr", i),     mem_addr,      vecs[i].e_addr);
      check($sformatf("v%0d_wdata", i),    mem_w_data,    vecs[i].e_wd);
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rd);
      @(posedge clk); #1;
    end

    // Starvation guard: both ports read continuously; aux wins exactly in cycles 4 and 9.
    for (int i = 0; i < 10; i++) begin
      logic exp_ag, prev_ag;
      exp_ag  = (i == 4) || (i == 9);
      prev_ag = (i == 5);
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      check($sformatf("st%0d_a_gnt", i),   32'(a_gnt),   32'(exp_ag));
      check($sformatf("st%0d_c_gnt", i),   32'(c_gnt),   32'(!exp_ag));
      check($sformatf("st%0d_c_stall", i), 32'(c_stall), 32'(exp_ag));
      check($sformatf("st%0d_a_rvalid", i), 32'(a_rvalid), (i == 0) ? 32'h0 : 32'(prev_ag));
      check($sformatf("st%0d_c_rvalid", i), 32'(c_rvalid), (i == 0) ? 32'h0 : 32'(!prev_ag));
      if (i > 0) check($sformatf("st%0d_rdata", i), rdata, prev_ag ? 32'h12345678 : 32'hDEADBEEF);
      @(posedge clk); #1;
    end

    // Withdrawing aux for a cycle clears the wait count: CPU wins the next contention.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    check("wd_c_gnt", 32'(c_gnt), 32'h1);
    check("wd_a_gnt", 32'(a_gnt), 32'h0);
    @(posedge clk); #1;

    // Reset pulled low while a granted CPU read is in flight.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("r6_c_gnt", 32'(c_gnt), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b1, 1'b1, 32'h10, 32'hBAD0BAD0, 1'b1, 1'b1, 32'h10, 32'hBAD1BAD1);
    @(negedge clk);
    check("r6_c_rvalid", 32'(c_rvalid), 32'h0);
    check("r6_w_en", 32'(mem_w_en), 32'h0);
    check("r6_gnts", {30'h0, c_gnt, a_gnt}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("r6_c_rvalid_hold", 32'(c_rvalid), 32'h0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("r6_mem_intact", mem[4], 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("r6_post_rvalid", 32'(c_rvalid), 32'h1);
    check("r6_post_rdata", rdata, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
